// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
//
// Handshake: start is a level sampled on every rising clk edge. It is accepted
// only in IDLE or DONE (busy=0). On acceptance a, b and cin are captured and
// need not be held afterwards. While busy=1 start is ignored. done is a
// one-cycle pulse marking sum/cout valid. sum/cout then hold until the next
// accepted start.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface : serial_adder_if

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder; the only arithmetic in the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : fa_bit

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first. Operands sit in
// right-shifting registers, the carry lives in a flip-flop between bits, and
// each sum bit enters the sum register at its MSB so that after WIDTH steps
// the result is aligned. The FSM state is exported for debug.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_if.slave        bus,
  output state_e               dbg_state_o
);

  // A 1-bit counter is still needed when WIDTH is 2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  fa_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: load on an accepted start, one bit step per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          // Counter parks on its last value instead of wrapping.
          state_d = ST_DONE;
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new start; DONE otherwise falls to IDLE.
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous clear of every datapath element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    bus.busy    = (state_q == ST_RUN);
    bus.done    = (state_q == ST_DONE);
    bus.sum     = sum_q;
    bus.cout    = cout_q;
    dbg_state_o = state_q;
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with hand-computed expected results.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W:0] exp_q[$];  // {cout, sum}

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the operand
  // inputs so any late capture would corrupt the result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum,
                          input logic exp_cout);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    exp_q.push_back({exp_cout, exp_sum});
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, (1 << W) - 1));
    bus.b     = W'($urandom_range(0, (1 << W) - 1));
    bus.cin   = 1'($urandom_range(0, 1));
  endtask

  // Counts remaining busy cycles (bounded), then checks the done cycle.
  task automatic finish_op(input string tag, input int exp_cycles);
    int   cyc = 0;
    logic early_done = 1'b0;
    logic [W:0] e;
    while (bus.busy === 1'b1 && cyc < 40) begin
      if (bus.done !== 1'b0) early_done = 1'b1;
      cyc++;
      tick();
    end
    check_eq({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cycles));
    check_eq({tag, " done_during_busy"}, 32'(early_done), 32'(0));
    check_eq({tag, " done"}, 32'(bus.done), 32'(1));
    if (exp_q.size() == 0) begin
      check_eq({tag, " scoreboard_empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, " sum"}, 32'(bus.sum), 32'(e[W-1:0]));
      check_eq({tag, " cout"}, 32'(bus.cout), 32'(e[W]));
    end
  endtask

  // One cycle after done: pulse gone, result held.
  task automatic check_hold(input string tag, input logic [W-1:0] exp_sum,
                            input logic exp_cout);
    tick();
    check_eq({tag, " done_drop"}, 32'(bus.done), 32'(0));
    check_eq({tag, " hold_sum"}, 32'(bus.sum), 32'(exp_sum));
    check_eq({tag, " hold_cout"}, 32'(bus.cout), 32'(exp_cout));
    check_eq({tag, " idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw_activity;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    check_eq("reset busy", 32'(bus.busy), 32'(0));
    check_eq("reset done", 32'(bus.done), 32'(0));
    check_eq("reset sum", 32'(bus.sum), 32'(0));
    check_eq("reset cout", 32'(bus.cout), 32'(0));
    check_eq("reset state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // 3C + 42 = 7E
    start_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
    check_eq("op1 busy_after_start", 32'(bus.busy), 32'(1));
    finish_op("op1", W);
    check_hold("op1", 8'h7E, 1'b0);

    // FF + 01 = 00, carry out
    start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    finish_op("op2", W);
    check_hold("op2", 8'h00, 1'b1);

    // A5 + 5A + 1 = 100
    start_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    finish_op("op3", W);
    check_hold("op3", 8'h00, 1'b1);

    // FF + FF + 1 = 1FF, all bits and carry set
    start_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    finish_op("op4", W);
    check_hold("op4", 8'hFF, 1'b1);

    // 10 + 01 with a spurious start in RUN cycle 3
    start_op(8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
    tick();
    tick();
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    tick();
    bus.start = 1'b0;
    check_eq("ign still_run", 32'(dbg_state), 32'(ST_RUN));
    finish_op("ign", W - 3);
    check_hold("ign", 8'h11, 1'b0);

    // Reset during RUN cycle 4 aborts without a done pulse
    start_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort busy", 32'(bus.busy), 32'(0));
    check_eq("abort done", 32'(bus.done), 32'(0));
    check_eq("abort sum", 32'(bus.sum), 32'(0));
    check_eq("abort cout", 32'(bus.cout), 32'(0));
    check_eq("abort state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    bus.start = 1'b1;
    tick();
    tick();
    check_eq("start_in_reset state", 32'(dbg_state), 32'(ST_IDLE));
    bus.start = 1'b0;
    rst = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_activity = 1'b1;
    end
    check_eq("abort no_done", 32'(saw_activity), 32'(0));
    start_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    finish_op("after_rst", W);
    check_hold("after_rst", 8'h02, 1'b0);

    // Back-to-back: new start presented in the DONE cycle
    start_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    finish_op("b2b_first", W);
    start_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    check_eq("b2b no_idle", 32'(dbg_state), 32'(ST_RUN));
    check_eq("b2b sum_cleared", 32'(bus.sum), 32'(0));
    finish_op("b2b_second", W);
    check_hold("b2b_second", 8'h00, 1'b1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder
